imem_port_arbiter: RTL and testbench

- Shares one 64-bit memory port between the instruction fetcher's prefetch-buffer refill and the execute stage's 32-bit load/store unit.
- One transaction outstanding at a time; handles wait states, a fetch-starvation guard, branch flush of in-flight fetches and a bus-timeout error.
- Sits between the fetch/LSU requesters and the memory; the memory's rdata feeds the fetcher's 64-bit mem input via if_rdata_o.

---
 rtl/v850_mem_pkg.sv | 14 +
 rtl/mem_timeout_ctr.sv | 28 ++
 rtl/imem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_imem_port_arbiter.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v850_mem_pkg.sv
// Shared types and widths for the 64-bit instruction/data memory port.
package v850_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IF_WAIT,
        LS_WAIT
    } arb_state_t;

    localparam int ADDR_W = 25;
    localparam int MEM_DW = 64;
    localparam int LS_DW  = 32;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter; expired flags the last allowed wait cycle.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt;

    // Abort is registered, so flag it one count early to land on TIMEOUT.
    assign expired = en && (cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != TO_W'(TIMEOUT)) begin
            cnt <= cnt + TO_W'(1);
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Single-outstanding arbiter sharing one 64-bit memory port
// between prefetch refill (IF) and the load/store unit (LS).
module imem_port_arbiter
    import v850_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 255,
    parameter int TO_W         = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [MEM_DW-1:0] if_rdata_o,
    input  logic              flush_i,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [LS_DW-1:0]  ls_wdata_i,
    input  logic [3:0]        ls_be_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [LS_DW-1:0]  ls_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [MEM_DW-1:0] mem_wdata_o,
    output logic [7:0]        mem_be_o,
    input  logic              mem_ready_i,
    input  logic [MEM_DW-1:0] mem_rdata_i,
    output logic              bus_err_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state;
    logic [SW-1:0] starve_cnt;
    logic          drop;
    logic          ls_hi;
    logic          idle;
    logic          if_win;
    logic          ls_win;
    logic          waiting;
    logic          expired;
    logic          done;

    always_comb begin
        idle    = rst_n && (state == IDLE);
        if_win  = idle && if_req_i && !flush_i &&
                  (!ls_req_i || starve_cnt == SW'(STARVE_LIMIT));
        ls_win  = idle && ls_req_i && !if_win;
        waiting = rst_n && (state != IDLE) && !mem_ready_i;
        done    = mem_ready_i || expired;
    end

    assign if_gnt_o    = if_win;
    assign ls_gnt_o    = ls_win;
    assign mem_req_o   = if_win || ls_win;
    assign mem_we_o    = ls_win && ls_we_i;
    assign mem_addr_o  = if_win ? if_addr_i :
                         ls_win ? ls_addr_i : '0;
    assign mem_wdata_o = ls_win ? {ls_wdata_i, ls_wdata_i} : '0;
    assign mem_be_o    = if_win ? 8'hFF :
                         !ls_win ? 8'h00 :
                         ls_addr_i[1] ? {ls_be_i, 4'h0} :
                                        {4'h0, ls_be_i};

    mem_timeout_ctr #(
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) u_to (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (mem_req_o),
        .en     (waiting),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            drop        <= 1'b0;
            ls_hi       <= 1'b0;
            if_rvalid_o <= 1'b0;
            ls_rvalid_o <= 1'b0;
            bus_err_o   <= 1'b0;
            if_rdata_o  <= '0;
            ls_rdata_o  <= '0;
        end else begin
            if_rvalid_o <= 1'b0;
            ls_rvalid_o <= 1'b0;
            bus_err_o   <= 1'b0;

            if (!if_req_i || if_win) begin
                starve_cnt <= '0;
            end else if (ls_win && starve_cnt != SW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            unique case (state)
                IDLE: begin
                    if (if_win) begin
                        state <= IF_WAIT;
                        drop  <= 1'b0;
                    end else if (ls_win) begin
                        state <= LS_WAIT;
                        ls_hi <= ls_addr_i[1];
                    end
                end
                IF_WAIT: begin
                    if (flush_i) drop <= 1'b1;
                    if (done) begin
                        state     <= IDLE;
                        bus_err_o <= !mem_ready_i;
                        // A flushed fetch is still drained, just not reported.
                        if (!(drop || flush_i)) begin
                            if_rvalid_o <= 1'b1;
                            if_rdata_o  <= mem_ready_i ? mem_rdata_i : '0;
                        end
                    end
                end
                LS_WAIT: begin
                    if (done) begin
                        state       <= IDLE;
                        bus_err_o   <= !mem_ready_i;
                        ls_rvalid_o <= 1'b1;
                        if (!mem_ready_i) ls_rdata_o <= '0;
                        else if (ls_hi)   ls_rdata_o <= mem_rdata_i[63:32];
                        else              ls_rdata_o <= mem_rdata_i[31:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed and random checks of imem_port_arbiter against a transaction model.
module tb_imem_port_arbiter;

    localparam int SL = 3;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_i;
    logic [24:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [63:0] if_rdata_o;
    logic        flush_i;
    logic        ls_req_i;
    logic        ls_we_i;
    logic [24:0] ls_addr_i;
    logic [31:0] ls_wdata_i;
    logic [3:0]  ls_be_i;
    logic        ls_gnt_o;
    logic        ls_rvalid_o;
    logic [31:0] ls_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [24:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_be_o;
    logic        mem_ready_i;
    logic [63:0] mem_rdata_i;
    logic        bus_err_o;

    always #5 clk = ~clk;

    imem_port_arbiter #(
        .STARVE_LIMIT(SL),
        .TIMEOUT     (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_gnt_o   (if_gnt_o),
        .if_rvalid_o(if_rvalid_o),
        .if_rdata_o (if_rdata_o),
        .flush_i    (flush_i),
        .ls_req_i   (ls_req_i),
        .ls_we_i    (ls_we_i),
        .ls_addr_i  (ls_addr_i),
        .ls_wdata_i (ls_wdata_i),
        .ls_be_i    (ls_be_i),
        .ls_gnt_o   (ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o),
        .ls_rdata_o (ls_rdata_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_be_o   (mem_be_o),
        .mem_ready_i(mem_ready_i),
        .mem_rdata_i(mem_rdata_i),
        .bus_err_o  (bus_err_o)
    );

    int checks = 0;
    int passed = 0;

    // Model: who owns the port, how long it has waited, its memory latency.
    int          m_owner;
    int          m_waited;
    int          m_lat;
    int          m_starve;
    bit          m_drop;
    bit          m_hi;
    int          lat_sel;
    bit          late_rdy;
    bit          rd_fix_en;
    logic [63:0] rd_fix;

    logic        e_if_gnt, e_ls_gnt, e_we;
    logic [24:0] e_addr;
    logic [63:0] e_wdata;
    logic [7:0]  e_be;
    logic        e_if_rv, e_ls_rv, e_err;
    logic [63:0] e_if_rdata;
    logic [31:0] e_ls_rdata;

    task automatic zero_inputs();
        if_req_i   = 0;
        if_addr_i  = '0;
        flush_i    = 0;
        ls_req_i   = 0;
        ls_we_i    = 0;
        ls_addr_i  = '0;
        ls_wdata_i = '0;
        ls_be_i    = '0;
        late_rdy   = 0;
    endtask

    task automatic cyc_begin();
        bit idle;
        idle = rst_n && m_owner == 0;
        e_if_gnt = idle && if_req_i && !flush_i &&
                   (!ls_req_i || m_starve >= SL);
        e_ls_gnt = idle && ls_req_i && !e_if_gnt;
        e_addr  = e_if_gnt ? if_addr_i : (e_ls_gnt ? ls_addr_i : 25'd0);
        e_we    = e_ls_gnt && ls_we_i;
        e_wdata = e_ls_gnt ? {2{ls_wdata_i}} : 64'd0;
        if (e_if_gnt)      e_be = 8'hFF;
        else if (e_ls_gnt) e_be = 8'(ls_be_i) << (ls_addr_i[1] ? 4 : 0);
        else               e_be = 8'h00;
        mem_ready_i = (rst_n && m_owner != 0 && m_waited + 1 == m_lat) ||
                      (late_rdy && m_owner == 0 && !e_if_gnt && !e_ls_gnt);
        mem_rdata_i = rd_fix_en ? rd_fix : {$urandom, $urandom};
        #1;
    endtask

    task automatic cyc_end();
        e_if_rv = 0;
        e_ls_rv = 0;
        e_err   = 0;
        if (!rst_n) begin
            m_owner    = 0;
            m_starve   = 0;
            m_drop     = 0;
            e_if_rdata = '0;
            e_ls_rdata = '0;
        end else begin
            if (!if_req_i || e_if_gnt) m_starve = 0;
            else if (e_ls_gnt && m_starve < SL) m_starve++;
            if (e_if_gnt || e_ls_gnt) begin
                m_owner  = e_if_gnt ? 1 : 2;
                m_waited = 0;
                m_drop   = 0;
                m_hi     = ls_addr_i[1];
                m_lat    = lat_sel > 0 ? lat_sel : $urandom_range(1, 6);
            end else if (m_owner != 0) begin
                m_waited++;
                if (m_owner == 1 && flush_i) m_drop = 1;
                if (mem_ready_i || m_waited == TO) begin
                    e_err = !mem_ready_i;
                    if (m_owner == 1 && !m_drop) begin
                        e_if_rv    = 1;
                        e_if_rdata = mem_ready_i ? mem_rdata_i : 64'd0;
                    end
                    if (m_owner == 2) begin
                        e_ls_rv    = 1;
                        e_ls_rdata = !mem_ready_i ? 32'd0 :
                                     m_hi ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
                    end
                    m_owner = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        zero_inputs();
        rst_n = 1;
        for (int i = 0; i < 12 && m_owner != 0; i++) begin
            cyc_begin();
            cyc_end();
        end
        cyc_begin();
        cyc_end();
    endtask

    task automatic test_reset();
        zero_inputs();
        rst_n    = 0;
        if_req_i = 1;
        ls_req_i = 1;
        for (int c = 0; c < 2; c++) begin
            cyc_begin();
            checks++;
            if ({if_gnt_o, ls_gnt_o, mem_req_o, mem_we_o, mem_addr_o,
                 mem_wdata_o, mem_be_o} !== '0)
                $display("FAIL reset_req got gnt=%b%b req=%b be=%h want 0",
                         if_gnt_o, ls_gnt_o, mem_req_o, mem_be_o);
            else passed++;
            checks++;
            if ({if_rvalid_o, ls_rvalid_o, bus_err_o, if_rdata_o, ls_rdata_o} !== '0)
                $display("FAIL reset_regs got rv=%b%b err=%b want 0",
                         if_rvalid_o, ls_rvalid_o, bus_err_o);
            else passed++;
            cyc_end();
        end
        quiet();
    endtask

    task automatic test_if_only();
        lat_sel   = 2;
        rd_fix_en = 1;
        rd_fix    = 64'h0123_4567_89AB_CDEF;
        for (int c = 0; c < 5; c++) begin
            if_req_i  = (c == 0);
            if_addr_i = 25'h10;
            cyc_begin();
            if (c == 0) begin
                checks++;
                if ({if_gnt_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o} !==
                    {3'b110, 8'hFF, 25'h10})
                    $display("FAIL if_grant got gnt=%b we=%b be=%h addr=%h want 1 0 ff 10",
                             if_gnt_o, mem_we_o, mem_be_o, mem_addr_o);
                else passed++;
            end
            checks++;
            if (c == 3 && {if_rvalid_o, if_rdata_o} !== {1'b1, rd_fix})
                $display("FAIL if_rvalid got %b %h want 1 %h",
                         if_rvalid_o, if_rdata_o, rd_fix);
            else if (c != 3 && if_rvalid_o !== 1'b0)
                $display("FAIL if_rvalid_early c=%0d got 1 want 0", c);
            else passed++;
            cyc_end();
        end
        rd_fix_en = 0;
        lat_sel   = 0;
        quiet();
    endtask

    task automatic test_priority();
        lat_sel   = 1;
        rd_fix_en = 1;
        rd_fix    = 64'hAAAA_BBBB_CCCC_DDDD;
        for (int c = 0; c < 3; c++) begin
            if_req_i  = 1;
            ls_req_i  = (c == 0);
            ls_addr_i = 25'h2;
            cyc_begin();
            if (c != 1) begin
                checks++;
                if ({if_gnt_o, ls_gnt_o} !== (c == 0 ? 2'b01 : 2'b10))
                    $display("FAIL prio_gnt c=%0d got if=%b ls=%b",
                             c, if_gnt_o, ls_gnt_o);
                else passed++;
            end
            if (c == 2) begin
                checks++;
                if ({ls_rvalid_o, ls_rdata_o} !== {1'b1, 32'hAAAA_BBBB})
                    $display("FAIL prio_ls_rdata got %b %h want 1 aaaabbbb",
                             ls_rvalid_o, ls_rdata_o);
                else passed++;
            end
            cyc_end();
        end
        rd_fix_en = 0;
        lat_sel   = 0;
        quiet();
    endtask

    task automatic test_starvation();
        lat_sel = 1;
        for (int c = 0; c < 16; c++) begin
            if_req_i = 1;
            ls_req_i = 1;
            cyc_begin();
            if (c % 2 == 0) begin
                checks++;
                if ({if_gnt_o, ls_gnt_o} !== ((c / 2) % 4 == 3 ? 2'b10 : 2'b01))
                    $display("FAIL starve_arb%0d got if=%b ls=%b",
                             c / 2, if_gnt_o, ls_gnt_o);
                else passed++;
            end
            cyc_end();
        end
        lat_sel = 0;
        quiet();
    endtask

    task automatic test_store();
        lat_sel = 2;
        for (int c = 0; c < 4; c++) begin
            ls_req_i   = (c == 0);
            ls_we_i    = 1;
            ls_addr_i  = 25'h4;
            ls_be_i    = 4'b0011;
            ls_wdata_i = 32'h1234_5678;
            cyc_begin();
            if (c == 0) begin
                checks++;
                if ({mem_we_o, mem_wdata_o, mem_be_o} !==
                    {1'b1, 64'h1234_5678_1234_5678, 8'h03})
                    $display("FAIL store_req got we=%b wd=%h be=%h",
                             mem_we_o, mem_wdata_o, mem_be_o);
                else passed++;
            end
            if (c >= 2) begin
                checks++;
                if (ls_rvalid_o !== (c == 3))
                    $display("FAIL store_done c=%0d got %b", c, ls_rvalid_o);
                else passed++;
            end
            cyc_end();
        end
        lat_sel = 0;
        quiet();
    endtask

    task automatic test_flush();
        lat_sel = 4;
        for (int c = 0; c < 7; c++) begin
            if_req_i = (c == 0 || c == 5);
            flush_i  = (c == 1);
            cyc_begin();
            checks++;
            if ({if_gnt_o, if_rvalid_o} !== {(c == 0 || c == 5), 1'b0})
                $display("FAIL flush c=%0d got gnt=%b rv=%b", c, if_gnt_o, if_rvalid_o);
            else passed++;
            cyc_end();
        end
        lat_sel = 0;
        quiet();
    endtask

    task automatic test_timeout();
        lat_sel = 100;
        for (int c = 0; c < 8; c++) begin
            ls_req_i = (c == 0);
            late_rdy = (c == 6);
            cyc_begin();
            if (c >= 1) begin
                checks++;
                if (c == 5 && {bus_err_o, ls_rvalid_o, ls_rdata_o} !== {2'b11, 32'd0})
                    $display("FAIL timeout got err=%b rv=%b rd=%h want 1 1 0",
                             bus_err_o, ls_rvalid_o, ls_rdata_o);
                else if (c != 5 && {bus_err_o, ls_rvalid_o} !== 2'b00)
                    $display("FAIL timeout_quiet c=%0d got err=%b rv=%b",
                             c, bus_err_o, ls_rvalid_o);
                else passed++;
            end
            cyc_end();
        end
        lat_sel = 0;
        quiet();
    endtask

    task automatic test_reset_mid();
        lat_sel = 100;
        for (int c = 0; c < 5; c++) begin
            if_req_i = (c == 0);
            rst_n    = (c != 2);
            late_rdy = (c == 3);
            cyc_begin();
            if (c == 2) begin
                checks++;
                if ({if_gnt_o, mem_req_o, mem_addr_o, mem_be_o} !== '0)
                    $display("FAIL rst_mid_req got req=%b addr=%h", mem_req_o, mem_addr_o);
                else passed++;
            end
            if (c >= 3) begin
                checks++;
                if ({if_rvalid_o, ls_rvalid_o, bus_err_o, if_rdata_o, ls_rdata_o} !== '0)
                    $display("FAIL rst_mid_regs c=%0d got rv=%b%b err=%b",
                             c, if_rvalid_o, ls_rvalid_o, bus_err_o);
                else passed++;
            end
            cyc_end();
        end
        lat_sel = 0;
        quiet();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst_n      = ($urandom % 80) != 0;
            if_req_i   = ($urandom % 4) != 0;
            if_addr_i  = 25'($urandom);
            flush_i    = ($urandom % 8) == 0;
            ls_req_i   = ($urandom % 2) != 0;
            ls_we_i    = ($urandom % 2) != 0;
            ls_addr_i  = 25'($urandom);
            ls_wdata_i = $urandom;
            ls_be_i    = 4'($urandom);
            late_rdy   = ($urandom % 4) == 0;
            cyc_begin();
            checks++;
            if ({if_gnt_o, ls_gnt_o, mem_req_o, mem_we_o} !==
                {e_if_gnt, e_ls_gnt, e_if_gnt | e_ls_gnt, e_we})
                $display("FAIL rnd_ctl c=%0d got %b%b%b%b want %b%b%b%b", c,
                         if_gnt_o, ls_gnt_o, mem_req_o, mem_we_o,
                         e_if_gnt, e_ls_gnt, e_if_gnt | e_ls_gnt, e_we);
            else passed++;
            checks++;
            if ({mem_addr_o, mem_wdata_o, mem_be_o} !== {e_addr, e_wdata, e_be})
                $display("FAIL rnd_bus c=%0d got %h %h %h want %h %h %h", c,
                         mem_addr_o, mem_wdata_o, mem_be_o, e_addr, e_wdata, e_be);
            else passed++;
            checks++;
            if ({if_rvalid_o, ls_rvalid_o, bus_err_o} !== {e_if_rv, e_ls_rv, e_err})
                $display("FAIL rnd_pulse c=%0d got %b%b%b want %b%b%b", c,
                         if_rvalid_o, ls_rvalid_o, bus_err_o, e_if_rv, e_ls_rv, e_err);
            else passed++;
            checks++;
            if ({if_rdata_o, ls_rdata_o} !== {e_if_rdata, e_ls_rdata})
                $display("FAIL rnd_data c=%0d got %h %h want %h %h", c,
                         if_rdata_o, ls_rdata_o, e_if_rdata, e_ls_rdata);
            else passed++;
            cyc_end();
        end
        quiet();
    endtask

    initial begin
        m_owner    = 0;
        m_waited   = 0;
        m_lat      = 1;
        m_starve   = 0;
        m_drop     = 0;
        m_hi       = 0;
        lat_sel    = 0;
        rd_fix_en  = 0;
        rd_fix     = '0;
        e_if_rdata = '0;
        e_ls_rdata = '0;
        e_if_rv    = 0;
        e_ls_rv    = 0;
        e_err      = 0;
        rst_n      = 0;
        mem_ready_i = 0;
        mem_rdata_i = '0;
        zero_inputs();
        @(negedge clk);
        test_reset();
        test_if_only();
        test_priority();
        test_starvation();
        test_store();
        test_flush();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
